// File: rtl/arith_op_scheduler_if.sv
// Request/response bundle for arith_op_scheduler: two requester channels plus a tagged result channel.
interface arith_op_scheduler_if #(parameter int WIDTH = 3);
  logic               req0_valid;
  logic               req0_ready;
  logic               req0_op;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic               req1_op;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/arith_op_scheduler.sv
// Round-robin shared add/shift-add multiply unit for two requesters, one op in flight.
// state | meaning
// IDLE  | waiting for a request; grants and accepts in the same cycle
// ADD   | single-cycle add of latched operands
// MUL   | WIDTH shift-add cycles, one multiplier bit per cycle
// RESP  | result held on rsp channel until rsp_ready
module arith_op_scheduler #(
  parameter int WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  arith_op_scheduler_if.slave bus,
  output logic          busy
);
  localparam int RW     = 2 * WIDTH;
  localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, MUL, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic [WIDTH-1:0]  a_q, a_nxt;
  logic [WIDTH-1:0]  b_q, b_nxt;
  logic              id_q, id_nxt;
  logic [RW-1:0]     acc, acc_nxt;
  logic [STEP_W-1:0] step, step_nxt;
  logic              grant0, grant1;
  logic [RW-1:0]     partial;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      acc        <= '0;
      step       <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      a_q        <= a_nxt;
      b_q        <= b_nxt;
      id_q       <= id_nxt;
      acc        <= acc_nxt;
      step       <= step_nxt;
    end
  end

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    partial = b_q[step] ? ({{WIDTH{1'b0}}, a_q} << step) : '0;

    state_nxt      = state;
    last_grant_nxt = last_grant;
    a_nxt          = a_q;
    b_nxt          = b_q;
    id_nxt         = id_q;
    acc_nxt        = acc;
    step_nxt       = step;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_id     = 1'b0;
    bus.rsp_data   = '0;
    busy           = (state != IDLE) & ~rst;

    case (state)
      IDLE: begin
        bus.req0_ready = grant0 & ~rst;
        bus.req1_ready = grant1 & ~rst;
        if (grant0 | grant1) begin
          a_nxt     = grant1 ? bus.req1_a : bus.req0_a;
          b_nxt     = grant1 ? bus.req1_b : bus.req0_b;
          id_nxt    = grant1;
          acc_nxt   = '0;
          step_nxt  = '0;
          state_nxt = (grant1 ? bus.req1_op : bus.req0_op) ? ADD : MUL;
        end
      end
      ADD: begin
        acc_nxt   = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
        state_nxt = RESP;
      end
      MUL: begin
        acc_nxt = acc + partial;
        if (step == STEP_W'(WIDTH - 1)) begin
          step_nxt  = '0;
          state_nxt = RESP;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      RESP: begin
        bus.rsp_valid = ~rst;
        bus.rsp_id    = id_q & ~rst;
        bus.rsp_data  = rst ? '0 : acc;
        if (bus.rsp_ready) begin
          last_grant_nxt = id_q;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_arith_op_scheduler.sv
// Directed bench for arith_op_scheduler: handshakes, latency, arbitration, back-pressure, reset and a full operand sweep.
module tb_arith_op_scheduler;
  localparam int WIDTH = 3;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_err = 0;
  int   n_chk = 0;

  arith_op_scheduler_if #(.WIDTH(WIDTH)) bus ();

  arith_op_scheduler #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int rid, input logic v, input logic op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (rid == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after the accept edge; waits (bounded) for the first rsp_valid cycle.
  task automatic wait_rsp(input logic [2*WIDTH-1:0] exp_data, input logic exp_id,
                          input int exp_lat, input string tag);
    int lat;
    lat = 1;
    while (!bus.rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, "_data"}, bus.rsp_data, exp_data);
    chk({tag, "_id"}, bus.rsp_id, exp_id);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_noready"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
  endtask

  // Lone-requester operation from IDLE with rsp_ready already high.
  task automatic run_op(input int rid, input logic op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [2*WIDTH-1:0] exp, input string tag);
    set_req(rid, 1'b1, op, a, b);
    #1;
    chk({tag, "_ready"}, (rid == 0) ? bus.req0_ready : bus.req1_ready, 1'b1);
    tick();
    set_req(rid, 1'b0, ~op, ~a, ~b);
    chk({tag, "_busy_acc"}, busy, 1'b1);
    wait_rsp(exp, rid[0], op ? 2 : WIDTH + 1, tag);
    tick();
    chk({tag, "_idle"}, {bus.rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();

    // Outputs stay quiet while reset is held, even with a request pending.
    set_req(0, 1'b1, 1'b1, 3'd1, 3'd1);
    #1;
    chk("rst_ready", bus.req0_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_valid", bus.rsp_valid, 1'b0);
    chk("post_rst_data", bus.rsp_data, 6'd0);
    chk("post_rst_id", bus.rsp_id, 1'b0);
    chk("post_rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    tick();

    // T1 / T2
    run_op(0, 1'b1, 3'd5, 3'd7, 6'd12, "t1");
    run_op(1, 1'b0, 3'd7, 3'd7, 6'd49, "t2");

    // T3: both valid continuously; last served was req1 so req0 goes first.
    set_req(0, 1'b1, 1'b0, 3'd3, 3'd2);
    set_req(1, 1'b1, 1'b1, 3'd1, 3'd1);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_ready0", bus.req0_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("t3_ready1", bus.req1_ready, (k % 2 == 0) ? 1'b0 : 1'b1);
      tick();
      if (k % 2 == 0) wait_rsp(6'd6, 1'b0, 4, "t3_mul");
      else            wait_rsp(6'd2, 1'b1, 2, "t3_add");
      tick();
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();

    // T4: back-pressure in RESP; a waiting requester is not accepted until after the handshake.
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b1, 3'd2, 3'd3);
    #1;
    chk("t4_ready", bus.req0_ready, 1'b1);
    tick();
    set_req(0, 1'b0, 1'b0, 3'd6, 3'd6);
    set_req(1, 1'b1, 1'b1, 3'd1, 3'd0);
    wait_rsp(6'd5, 1'b0, 2, "t4");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hold_valid", bus.rsp_valid, 1'b1);
      chk("t4_hold_data", bus.rsp_data, 6'd5);
      chk("t4_hold_id", bus.rsp_id, 1'b0);
      chk("t4_hold_noready", bus.req1_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t4_hs_noready", bus.req1_ready, 1'b0);
    tick();
    chk("t4_resume_ready", bus.req1_ready, 1'b1);
    chk("t4_resume_valid", bus.rsp_valid, 1'b0);
    tick();
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_rsp(6'd1, 1'b1, 2, "t4b");
    tick();
    run_op(0, 1'b1, 3'd0, 3'd0, 6'd0, "t4c");

    // T5: reset during MUL step 1 drops the op and restores req0 priority.
    set_req(1, 1'b1, 1'b0, 3'd7, 3'd7);
    #1;
    chk("t5_accept", bus.req1_ready, 1'b1);
    tick();
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_valid", bus.rsp_valid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_valid", bus.rsp_valid, 1'b0);
    chk("t5_data", bus.rsp_data, 6'd0);
    chk("t5_id", bus.rsp_id, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_no_rsp", {bus.rsp_valid, busy}, 2'b00);
    end
    set_req(0, 1'b1, 1'b1, 3'd1, 3'd2);
    set_req(1, 1'b1, 1'b1, 3'd4, 3'd4);
    #1;
    chk("t5_grant0", bus.req0_ready, 1'b1);
    chk("t5_grant1", bus.req1_ready, 1'b0);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_rsp(6'd3, 1'b0, 2, "t5");
    tick();

    // T6: all operand pairs, both ops, both requesters.
    for (int rid = 0; rid < 2; rid++) begin
      for (int op = 0; op < 2; op++) begin
        for (int a = 0; a < 8; a++) begin
          for (int b = 0; b < 8; b++) begin
            run_op(rid, op[0], 3'(a), 3'(b), (op == 1) ? 6'(a + b) : 6'(a * b), "t6");
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
